// File: rtl/w5300_bus_responder_pkg.sv
// rtl/w5300_bus_responder_pkg.sv - W5300 register constants and responder FSM state type
package w5300_bus_responder_pkg;

   localparam logic [9:0]  IDR_ADDR  = 10'h0FE;
   localparam logic [15:0] IDR_VALUE = 16'h5300;
   localparam logic [15:0] MR_RESET  = 16'h3800;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RD_DRIVE = 2'd2,
      WR_ACT   = 2'd3
   } resp_state_t;

endpackage

// File: rtl/w5300_sync2.sv
// rtl/w5300_sync2.sv - parameterized-width two-flop synchronizer with selectable reset value
module w5300_sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/w5300_bus_responder.sv
// rtl/w5300_bus_responder.sv - chip-side W5300 16-bit direct-bus target with word register file
// Define W5300_RESP_PROTOCOL_CHECK_EN to build in the sticky bus-protocol checker driving err.
module w5300_bus_responder
   import w5300_bus_responder_pkg::*;
#(
   parameter int DEPTH   = 512,
   parameter int RD_LAT  = 2,
   parameter int SYNC_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        w_rst_n,
   input  logic        cs_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic [9:0]  addr,
   inout  wire  [15:0] data,
   output logic [15:0] wr_cnt,
   output logic [15:0] rd_cnt,
   output logic        err
);

   localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW      = $clog2(RD_LAT) + 1;
   localparam logic [CW-1:0] RD_LAST = CW'(RD_LAT - 1);

   logic [3:0] ctl_s;
   logic [9:0] addr_s;

   generate
      if (SYNC_EN != 0) begin : g_sync
         w5300_sync2 #(.WIDTH(4), .RST_VAL(4'hF)) u_sync_ctl (
            .clk (clk),
            .rst (rst),
            .d   ({cs_n, rd_n, wr_n, w_rst_n}),
            .q   (ctl_s)
         );
         w5300_sync2 #(.WIDTH(10), .RST_VAL(10'h000)) u_sync_addr (
            .clk (clk),
            .rst (rst),
            .d   (addr),
            .q   (addr_s)
         );
      end else begin : g_direct
         assign ctl_s  = {cs_n, rd_n, wr_n, w_rst_n};
         assign addr_s = addr;
      end
   endgenerate

   logic cs_s, rd_s, wr_s, chip_rst;
   assign cs_s     = ctl_s[3];
   assign rd_s     = ctl_s[2];
   assign wr_s     = ctl_s[1];
   assign chip_rst = ~ctl_s[0];

   // 16-bit mode: the byte-lane bit never selects anything
   logic unused_addr_lsb;
   assign unused_addr_lsb = addr_s[0];

   logic rd_stb, wr_stb, rd_stb_q, wr_stb_q;
   logic rd_fall, rd_rise, wr_fall, wr_rise;
   assign rd_stb  = ~cs_s & ~rd_s;
   assign wr_stb  = ~cs_s & ~wr_s;
   assign rd_fall = rd_stb & ~rd_stb_q;
   assign rd_rise = ~rd_stb & rd_stb_q;
   assign wr_fall = wr_stb & ~wr_stb_q;
   assign wr_rise = ~wr_stb & wr_stb_q;

   resp_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [8:0]    word_q, word_d;
   logic [15:0]   rd_q, rd_d;
   logic          oe_q, oe_d;
   logic [15:0]   wr_cnt_q, wr_cnt_d;
   logic [15:0]   rd_cnt_q, rd_cnt_d;
   logic          mem_we;

   // Unwritten words read as their reset value, so clearing valid_q resets the whole file
   logic [15:0]      mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [AW-1:0]    mem_idx;
   logic             in_range, is_idr, is_mr;
   logic [15:0]      rd_word;

   assign mem_idx  = word_q[AW-1:0];
   assign in_range = {1'b0, word_q} < 10'(DEPTH);
   assign is_idr   = word_q == IDR_ADDR[9:1];
   assign is_mr    = word_q == 9'd0;

   always_comb begin
      rd_word = 16'h0000;
      if (is_idr) begin
         rd_word = IDR_VALUE;
      end else if (in_range) begin
         if (valid_q[mem_idx]) begin
            rd_word = mem_q[mem_idx];
         end else if (is_mr) begin
            rd_word = MR_RESET;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         word_q   <= '0;
         rd_q     <= '0;
         oe_q     <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         valid_q  <= '0;
         rd_stb_q <= 1'b0;
         wr_stb_q <= 1'b0;
      end else begin
         rd_stb_q <= rd_stb;
         wr_stb_q <= wr_stb;
         if (chip_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            rd_q     <= '0;
            oe_q     <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            valid_q  <= '0;
         end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            rd_q     <= rd_d;
            oe_q     <= oe_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            if (mem_we) begin
               valid_q[mem_idx] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_idx] <= data;
      end
   end

   // Write wins when both strobes fall in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wr_fall) begin
               state_d = WR_ACT;
            end else if (rd_fall) begin
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (rd_rise) begin
               state_d = IDLE;
            end else if (cnt_q == RD_LAST) begin
               state_d = RD_DRIVE;
            end
         end
         RD_DRIVE: if (rd_rise) state_d = IDLE;
         WR_ACT:   if (wr_rise) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = '0;
      word_d   = word_q;
      rd_d     = rd_q;
      oe_d     = 1'b0;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      mem_we   = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_fall || rd_fall) begin
               word_d = addr_s[9:1];
            end
         end
         RD_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (rd_rise) begin
               rd_cnt_d = rd_cnt_q + 16'd1;
            end else if (cnt_q == RD_LAST) begin
               rd_d = rd_word;
               oe_d = 1'b1;
            end
         end
         RD_DRIVE: begin
            if (rd_rise) begin
               rd_cnt_d = rd_cnt_q + 16'd1;
            end else begin
               oe_d = 1'b1;
            end
         end
         WR_ACT: begin
            if (wr_rise) begin
               wr_cnt_d = wr_cnt_q + 16'd1;
               mem_we   = in_range & ~is_idr & ~chip_rst;
            end
         end
         default: ;
      endcase
   end

   // Raw write strobe gates the driver so a host write never fights read data
   logic drive_en;
   assign drive_en = oe_q & (cs_n | wr_n);
   assign data     = drive_en ? rd_q : 16'bz;
   assign wr_cnt   = wr_cnt_q;
   assign rd_cnt   = rd_cnt_q;

`ifdef W5300_RESP_PROTOCOL_CHECK_EN
   logic       err_q, err_d, cs_prev_q, viol;
   logic [9:0] addr_prev_q;

   always_comb begin
      viol  = (rd_stb & wr_stb)
            | ((rd_stb | wr_stb) & (rd_stb_q | wr_stb_q) & (addr_s != addr_prev_q))
            | (cs_s & ~cs_prev_q & (~rd_s | ~wr_s));
      err_d = chip_rst ? 1'b0 : (err_q | viol);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q       <= 1'b0;
         cs_prev_q   <= 1'b1;
         addr_prev_q <= '0;
      end else begin
         err_q       <= err_d;
         cs_prev_q   <= cs_s;
         addr_prev_q <= addr_s;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
